program_sequencer: RTL
======================

// Module: program_sequencer
// PURPOSE
//  Run-control unit between ProgramMemory/InstructionDecoder and RF_ALU_CY_A_module; replaces the free-running PC.
//  Holds the program address, sequences run/halt/single-step/jump, and gates the decoder's enables.
//  A datapath state change (Reg/CY/A write, CY clear) happens only in cycles the sequencer marks as executing.
//  Ends the program at END_ADDR by halting or wrapping.
// PARAMETERS
//  ADDR_W    5   program address width (matches ProgramMemory depth 2**ADDR_W)
//  END_ADDR  31  last program address; reaching it triggers end-of-program handling
//  WRAP      0   1: after END_ADDR continue at 0 in RUN; 0: enter DONE
// PORTS
//  clk         in   1       clock, rising edge
//  Reset       in   1       synchronous, active-high
//  Start       in   1       level; IDLE->RUN, DONE->RUN from address 0
//  Stop        in   1       level; RUN->IDLE
//  Step        in   1       pulse; IDLE: execute exactly one instruction
//  JmpEn       in   1       IDLE only: load Addr from JmpAddr
//  JmpAddr     in   ADDR_W  jump target
//  RegCE_i     in   1       from InstructionDecoder Reg_CE
//  CY_CE_i     in   1       from InstructionDecoder CY_CE
//  A_CE_i      in   1       from InstructionDecoder A_CE
//  nResetCY_i  in   1       from InstructionDecoder nResetCY (active-low)
//  Addr        out  ADDR_W  registered program address to ProgramMemory
//  RegCE       out  1       RegCE_i & Exec
//  CY_CE       out  1       CY_CE_i & Exec
//  A_CE        out  1       A_CE_i & Exec
//  nResetCY    out  1       nResetCY_i | ~Exec (inactive high when not executing)
//  Running     out  1       state==RUN
//  Done        out  1       state==DONE
//  BpHit       out  1       sticky breakpoint flag (BREAKPOINT_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE, Addr=0, BpHit=0; all gated enables inactive (RegCE/CY_CE/A_CE=0, nResetCY=1).
//  States: IDLE, RUN, STEP, DONE (2-bit encoding). Exec = (RUN & ~bp_block) | STEP; combinational.
//  Executing cycle: decoder outputs for Addr pass through; at the clk edge datapath commits and Addr advances.
//  Advance: Addr==END_ADDR ? (WRAP ? 0 : hold, state->DONE) : Addr+1. No arithmetic overflow: END_ADDR <= 2**ADDR_W-1.
//  IDLE: priority Start > Step > JmpEn. Start->RUN; Step->STEP; JmpEn: Addr<=JmpAddr, stay IDLE.
//  RUN: Stop -> IDLE after this cycle (the cycle's instruction still executes); else stay RUN.
//  STEP: lasts exactly 1 cycle, executes one instruction, -> IDLE (or DONE at END_ADDR, WRAP=0). Step held high
//        does not re-step: a new step needs Step low for >=1 cycle (edge-detected with registered Step).
//  DONE: Addr held at END_ADDR, no execution; Start -> Addr<=0, RUN. Step/Stop/JmpEn ignored.
//  Start and Stop both high in RUN: Stop wins. Start ignored in RUN/STEP; JmpEn ignored outside IDLE.
//  Reset in any state/mid-step overrides all inputs at that edge; datapath is reset by the same Reset.
//  Latency: Start at edge N -> first executed instruction in cycle N+1 at current Addr.
// CONFIGURATION
//  Macro SEQ_BREAKPOINT_EN. Defined: extra inputs BpEn (1), BpAddr (ADDR_W).
//   In RUN, if BpEn & Addr==BpAddr & not first RUN cycle: bp_block=1, instruction NOT executed, Addr held,
//   -> IDLE, BpHit<=1. BpHit cleared by Start, Step, or Reset. First RUN cycle after entry skips the compare
//   so Start resumes past the breakpoint. STEP never checks breakpoints.
//  Not defined: ports absent, bp_block=0, BpHit tied 0.
// STRUCTURE
//  Shared package seq_pkg: typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_STEP, SEQ_DONE} seq_state_t; default ADDR_W.
//  One sub-module: seq_addr_counter (ADDR_W register with load/advance/wrap/hold, terminal flag at END_ADDR).
//  FSM, edge detect, breakpoint compare and enable gating stay in program_sequencer.
// TESTING
//  1 Reset=1 for 2 cycles with RegCE_i=1 -> Addr=0, RegCE=0, nResetCY=1, Running=0, Done=0.
//  2 Start pulse in IDLE, WRAP=0, END_ADDR=31 -> Addr 0..31 one per cycle, RegCE follows RegCE_i; at 31 -> Done=1, Addr=31.
//  3 Step held high 5 cycles in IDLE at Addr=4 -> exactly one Exec cycle, Addr=5; lower/raise Step -> Addr=6.
//  4 RUN at Addr=10, Stop and Start high at same edge -> instr 10 executes, Addr=11, state IDLE.
//  5 IDLE, JmpEn=1 JmpAddr=20, then Start -> executes 20,21..; WRAP=1: after 31 Addr=0, still Running.
//  6 SEQ_BREAKPOINT_EN, BpEn=1 BpAddr=7, Start at 0 -> 0..6 execute, at 7 no enables, IDLE, BpHit=1, Addr=7;
//    Start again -> 7 executes, BpHit=0, continues 8...

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the program sequencer and its address counter.
package seq_pkg;

    // Run-control states, 2-bit encoding.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_STEP = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    // Default program address width (ProgramMemory depth 2**SEQ_ADDR_W).
    localparam int SEQ_ADDR_W   = 5;
    // Default last program address.
    localparam int SEQ_END_ADDR = 31;

endpackage : seq_pkg

// File: rtl/seq_addr_counter.sv
// Program address register: load, advance, wrap or hold at the last address,
// and a terminal flag while the address sits on END_ADDR.
module seq_addr_counter
    import seq_pkg::*;
#(
    parameter int ADDR_W   = SEQ_ADDR_W,
    parameter int END_ADDR = SEQ_END_ADDR,
    parameter bit WRAP     = 1'b0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              advance_en,
    output logic [ADDR_W-1:0] addr,
    output logic              at_end
);

    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    assign at_end = (addr_q == END_A);
    assign addr   = addr_q;

    // Next address: a load beats an advance; the last address wraps or holds.
    always_comb begin
        // NOTE: every path starts from a default so no latch is inferred.
        addr_d = addr_q;
        if (load_en) begin
            addr_d = load_addr;
        end else if (advance_en) begin
            if (at_end) begin
                addr_d = WRAP ? '0 : addr_q;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Address register with synchronous reset to 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (Reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule : seq_addr_counter

// File: rtl/program_sequencer.sv
// Run-control sequencer: holds the program address, sequences run / halt /
// single-step / jump, and gates the decoder enables so the datapath only
// changes state in executing cycles.
// Optional breakpoint support is built when SEQ_BREAKPOINT_EN is defined.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W   = SEQ_ADDR_W,
    parameter int END_ADDR = SEQ_END_ADDR,
    parameter bit WRAP     = 1'b0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Step,
    input  logic              JmpEn,
    input  logic [ADDR_W-1:0] JmpAddr,
    input  logic              RegCE_i,
    input  logic              CY_CE_i,
    input  logic              A_CE_i,
    input  logic              nResetCY_i,
`ifdef SEQ_BREAKPOINT_EN
    input  logic              BpEn,
    input  logic [ADDR_W-1:0] BpAddr,
`endif
    output logic [ADDR_W-1:0] Addr,
    output logic              RegCE,
    output logic              CY_CE,
    output logic              A_CE,
    output logic              nResetCY,
    output logic              Running,
    output logic              Done,
    output logic              BpHit
);

    seq_state_t        state_q, state_d;
    logic              step_q, step_d;
    logic              step_rise;
    logic              exec;
    logic              bp_block;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic              advance_en;
    logic              at_end;

    seq_addr_counter #(
        .ADDR_W  (ADDR_W),
        .END_ADDR(END_ADDR),
        .WRAP    (WRAP)
    ) u_addr (
        .clk       (clk),
        .Reset     (Reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .advance_en(advance_en),
        .addr      (Addr),
        .at_end    (at_end)
    );

    // A held Step only counts once: it must be seen low before it steps again.
    assign step_d    = Step;
    assign step_rise = Step & ~step_q;

    // State register and registered Step.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next state plus address-counter control.
    always_comb begin
        state_d    = state_q;
        load_en    = 1'b0;
        load_addr  = '0;
        advance_en = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (Start) begin
                    state_d = SEQ_RUN;
                end else if (step_rise) begin
                    state_d = SEQ_STEP;
                end else if (JmpEn) begin
                    load_en   = 1'b1;
                    load_addr = JmpAddr;
                end
            end
            SEQ_RUN: begin
                if (bp_block) begin
                    state_d = SEQ_IDLE;
                end else begin
                    advance_en = 1'b1;
                    if (at_end && !WRAP) begin
                        state_d = SEQ_DONE;
                    end else if (Stop) begin
                        state_d = SEQ_IDLE;
                    end
                end
            end
            SEQ_STEP: begin
                advance_en = 1'b1;
                state_d    = (at_end && !WRAP) ? SEQ_DONE : SEQ_IDLE;
            end
            SEQ_DONE: begin
                if (Start) begin
                    state_d   = SEQ_RUN;
                    load_en   = 1'b1;
                    load_addr = '0;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Execute qualification and decoder-enable gating.
    always_comb begin
        exec     = ((state_q == SEQ_RUN) && !bp_block) || (state_q == SEQ_STEP);
        RegCE    = RegCE_i & exec;
        CY_CE    = CY_CE_i & exec;
        A_CE     = A_CE_i & exec;
        nResetCY = nResetCY_i | ~exec;
        Running  = (state_q == SEQ_RUN);
        Done     = (state_q == SEQ_DONE);
    end

`ifdef SEQ_BREAKPOINT_EN
    logic first_run_q, first_run_d;
    logic bp_hit_q, bp_hit_d;

    // Breakpoint compare, skipped on the first RUN cycle so Start resumes past it.
    always_comb begin
        bp_block = (state_q == SEQ_RUN) && BpEn && (Addr == BpAddr) && !first_run_q;
    end

    // First-RUN-cycle marker and sticky hit flag.
    always_comb begin
        first_run_d = (state_d == SEQ_RUN) && (state_q != SEQ_RUN);
        bp_hit_d    = bp_hit_q;
        if (bp_block) begin
            bp_hit_d = 1'b1;
        end else if (Start || Step) begin
            bp_hit_d = 1'b0;
        end
    end

    // Breakpoint state registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            first_run_q <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            first_run_q <= first_run_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    assign BpHit = bp_hit_q;
`else
    assign bp_block = 1'b0;
    assign BpHit    = 1'b0;
`endif

endmodule : program_sequencer
